uart_cmd_slave: RTL and testbench

Device-side endpoint of the host command link inside the logic-analyzer digital core. It receives two UART bytes (high, then low) and assembles them into one 16-bit command for the command/config unit. It returns one 8-bit response byte over UART when the command unit requests it. It is the responder for the host-side command master: it must interoperate bit-exactly with that master's 8N1 framing and its 16-bit-command / 8-bit-response exchange.

---
 rtl/la_comm_pkg.sv | 11 +
 rtl/uart_cmd_slave_if.sv | 26 ++
 rtl/uart_tx_byte.sv | 93 +++++++++
 rtl/uart_cmd_slave.sv | 199 +++++++++++++++++++
 tb/tb_uart_cmd_slave.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/la_comm_pkg.sv
// Shared types and constants for the host command link (UART framing, FSM states).
package la_comm_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic       {WAIT_HI, WAIT_LO}                    asm_state_t;
  typedef enum logic       {TX_IDLE, TX_SHIFT}                   tx_state_t;

endpackage : la_comm_pkg

// File: rtl/uart_cmd_slave_if.sv
// Host-link bundle between the command slave and its surroundings.
interface uart_cmd_slave_if;

  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        tx_busy;
  logic        resp_sent;
  logic        frm_err;
  logic        ovr;

  modport slave (
    input  RX, clr_cmd_rdy, resp, send_resp,
    output TX, cmd, cmd_rdy, tx_busy, resp_sent, frm_err, ovr
  );

  modport master (
    output RX, clr_cmd_rdy, resp, send_resp,
    input  TX, cmd, cmd_rdy, tx_busy, resp_sent, frm_err, ovr
  );

endinterface : uart_cmd_slave_if

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter: start bit, 8 data bits LSB first, stop bit.
module uart_tx_byte
  import la_comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 868
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_send,
  input  logic [UART_DATA_BITS-1:0] i_data,
  output logic                      o_tx,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);
  localparam int unsigned BIT_W = $clog2(UART_FRAME_BITS);

  tx_state_t               r_state,    w_state_nx;
  logic [CNT_W-1:0]        r_baud_cnt, w_baud_nx;
  logic [BIT_W-1:0]        r_bit_cnt,  w_bit_nx;
  logic [UART_DATA_BITS:0] r_shift,    w_shift_nx;
  logic                    r_tx,       w_tx_nx;
  logic                    r_busy,     w_busy_nx;
  logic                    r_done,     w_done_nx;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= TX_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_baud_cnt <= w_baud_nx;
      r_bit_cnt  <= w_bit_nx;
      r_shift    <= w_shift_nx;
      r_tx       <= w_tx_nx;
      r_busy     <= w_busy_nx;
      r_done     <= w_done_nx;
    end
  end

  // Next-state: shift register holds remaining data bits plus the stop bit
  always_comb begin
    w_state_nx = r_state;
    w_baud_nx  = r_baud_cnt;
    w_bit_nx   = r_bit_cnt;
    w_shift_nx = r_shift;
    w_tx_nx    = r_tx;
    w_busy_nx  = r_busy;
    w_done_nx  = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (i_send) begin
          w_state_nx = TX_SHIFT;
          w_shift_nx = {1'b1, i_data};
          w_baud_nx  = CNT_W'(BAUD_DIV - 1);
          w_bit_nx   = '0;
          w_tx_nx    = 1'b0;
          w_busy_nx  = 1'b1;
        end
      end
      TX_SHIFT: begin
        if (r_baud_cnt == '0) begin
          if (r_bit_cnt == BIT_W'(UART_FRAME_BITS - 1)) begin
            w_state_nx = TX_IDLE;
            w_tx_nx    = 1'b1;
            w_busy_nx  = 1'b0;
            w_done_nx  = 1'b1;
          end else begin
            w_tx_nx    = r_shift[0];
            w_shift_nx = {1'b1, r_shift[UART_DATA_BITS:1]};
            w_bit_nx   = r_bit_cnt + BIT_W'(1);
            w_baud_nx  = CNT_W'(BAUD_DIV - 1);
          end
        end else begin
          w_baud_nx = r_baud_cnt - CNT_W'(1);
        end
      end
      default: w_state_nx = TX_IDLE;
    endcase
  end

  assign o_tx   = r_tx;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule : uart_tx_byte

// File: rtl/uart_cmd_slave.sv
// Device-side host-link endpoint: two RX bytes -> 16-bit command, one TX response byte.
module uart_cmd_slave
  import la_comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV     = 868,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input logic             clk,
  input logic             rst,
  uart_cmd_slave_if.slave bus
);

  localparam int unsigned CNT_W  = $clog2(BAUD_DIV);
  localparam int unsigned BIT_W  = $clog2(UART_DATA_BITS);
  localparam int unsigned TO_LIM = TIMEOUT_BITS * BAUD_DIV;
  localparam int unsigned TO_W   = $clog2(TO_LIM + 1);

  logic                      r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_t                 r_rx_state, w_rx_state_nx;
  logic [CNT_W-1:0]          r_baud_cnt, w_baud_nx;
  logic [BIT_W-1:0]          r_bit_cnt,  w_bit_nx;
  logic [UART_DATA_BITS-1:0] r_rx_shift, w_shift_nx;
  logic                      w_byte_vld, w_start_det, w_frm_err_nx, r_frm_err;

  asm_state_t                r_asm_state, w_asm_nx;
  logic [UART_DATA_BITS-1:0] r_hi, w_hi_nx;
  logic [TO_W-1:0]           r_to_cnt, w_to_nx;
  logic                      r_to_run, w_to_run_nx;
  logic [15:0]               r_cmd, w_cmd_nx;
  logic                      r_cmd_rdy, w_cmd_rdy_nx;
  logic                      r_ovr, w_ovr_nx;

  logic                      w_tx, w_tx_busy, w_resp_sent;

  // Two-flop synchronizer plus previous value for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= bus.RX;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // RX and assembler registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state  <= RX_IDLE;
      r_baud_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_rx_shift  <= '0;
      r_frm_err   <= 1'b0;
      r_asm_state <= WAIT_HI;
      r_hi        <= '0;
      r_to_cnt    <= '0;
      r_to_run    <= 1'b0;
      r_cmd       <= '0;
      r_cmd_rdy   <= 1'b0;
      r_ovr       <= 1'b0;
    end else begin
      r_rx_state  <= w_rx_state_nx;
      r_baud_cnt  <= w_baud_nx;
      r_bit_cnt   <= w_bit_nx;
      r_rx_shift  <= w_shift_nx;
      r_frm_err   <= w_frm_err_nx;
      r_asm_state <= w_asm_nx;
      r_hi        <= w_hi_nx;
      r_to_cnt    <= w_to_nx;
      r_to_run    <= w_to_run_nx;
      r_cmd       <= w_cmd_nx;
      r_cmd_rdy   <= w_cmd_rdy_nx;
      r_ovr       <= w_ovr_nx;
    end
  end

  // RX framing: mid-bit sampling, glitch reject on start, stop-bit check
  always_comb begin
    w_rx_state_nx = r_rx_state;
    w_baud_nx     = r_baud_cnt;
    w_bit_nx      = r_bit_cnt;
    w_shift_nx    = r_rx_shift;
    w_byte_vld    = 1'b0;
    w_start_det   = 1'b0;
    w_frm_err_nx  = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (r_rx_prev && !r_rx_sync) begin
          w_rx_state_nx = RX_START;
          w_baud_nx     = CNT_W'(BAUD_DIV / 2 - 1);
          w_start_det   = 1'b1;
        end
      end
      RX_START: begin
        if (r_baud_cnt == '0) begin
          if (r_rx_sync) begin
            w_rx_state_nx = RX_IDLE;
          end else begin
            w_rx_state_nx = RX_DATA;
            w_baud_nx     = CNT_W'(BAUD_DIV - 1);
            w_bit_nx      = '0;
          end
        end else begin
          w_baud_nx = r_baud_cnt - CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (r_baud_cnt == '0) begin
          w_shift_nx = {r_rx_sync, r_rx_shift[UART_DATA_BITS-1:1]};
          w_baud_nx  = CNT_W'(BAUD_DIV - 1);
          if (r_bit_cnt == BIT_W'(UART_DATA_BITS - 1)) begin
            w_rx_state_nx = RX_STOP;
          end else begin
            w_bit_nx = r_bit_cnt + BIT_W'(1);
          end
        end else begin
          w_baud_nx = r_baud_cnt - CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (r_baud_cnt == '0) begin
          w_rx_state_nx = RX_IDLE;
          if (r_rx_sync) w_byte_vld   = 1'b1;
          else           w_frm_err_nx = 1'b1;
        end else begin
          w_baud_nx = r_baud_cnt - CNT_W'(1);
        end
      end
      default: w_rx_state_nx = RX_IDLE;
    endcase
  end

  // Assembler: high/low pairing, inter-byte timeout, cmd_rdy with set-over-clear
  always_comb begin
    w_asm_nx     = r_asm_state;
    w_hi_nx      = r_hi;
    w_to_nx      = r_to_cnt;
    w_to_run_nx  = r_to_run;
    w_cmd_nx     = r_cmd;
    w_cmd_rdy_nx = r_cmd_rdy;
    w_ovr_nx     = 1'b0;
    if (bus.clr_cmd_rdy) w_cmd_rdy_nx = 1'b0;
    case (r_asm_state)
      WAIT_HI: begin
        if (w_byte_vld) begin
          w_asm_nx    = WAIT_LO;
          w_hi_nx     = r_rx_shift;
          w_to_nx     = '0;
          w_to_run_nx = 1'b1;
        end
      end
      WAIT_LO: begin
        if (w_frm_err_nx) begin
          w_asm_nx    = WAIT_HI;
          w_to_run_nx = 1'b0;
        end else if (w_byte_vld) begin
          w_asm_nx     = WAIT_HI;
          w_to_run_nx  = 1'b0;
          w_cmd_nx     = {r_hi, r_rx_shift};
          w_cmd_rdy_nx = 1'b1;
          w_ovr_nx     = r_cmd_rdy;
        end else if (r_to_run) begin
          if (w_start_det) begin
            w_to_run_nx = 1'b0;
          end else if (r_to_cnt == TO_W'(TO_LIM)) begin
            w_asm_nx    = WAIT_HI;
            w_to_run_nx = 1'b0;
          end else begin
            w_to_nx = r_to_cnt + TO_W'(1);
          end
        end
      end
      default: w_asm_nx = WAIT_HI;
    endcase
  end

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx (
    .clk    (clk),
    .rst    (rst),
    .i_send (bus.send_resp),
    .i_data (bus.resp),
    .o_tx   (w_tx),
    .o_busy (w_tx_busy),
    .o_done (w_resp_sent)
  );

  assign bus.TX        = w_tx;
  assign bus.tx_busy   = w_tx_busy;
  assign bus.resp_sent = w_resp_sent;
  assign bus.cmd       = r_cmd;
  assign bus.cmd_rdy   = r_cmd_rdy;
  assign bus.frm_err   = r_frm_err;
  assign bus.ovr       = r_ovr;

endmodule : uart_cmd_slave

// File: tb/tb_uart_cmd_slave.sv
// Bench for uart_cmd_slave: byte-level host model and bit-centre TX decoding.
module tb_uart_cmd_slave;

  localparam int unsigned BD = 16;
  localparam int unsigned TB = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_cmd_slave_if bus();

  uart_cmd_slave #(
    .BAUD_DIV     (BD),
    .TIMEOUT_BITS (TB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // pulse monitors and cycle counter
  int cnt_frm = 0, cnt_ovr = 0, cnt_sent = 0, cyc_cnt = 0;
  always @(negedge clk) begin
    cyc_cnt++;
    if (bus.frm_err === 1'b1)   cnt_frm++;
    if (bus.ovr === 1'b1)       cnt_ovr++;
    if (bus.resp_sent === 1'b1) cnt_sent++;
  end

  // host-level reference model of the command link
  logic        m_hi_vld = 1'b0;
  logic [7:0]  m_hi     = 8'h00;
  logic [15:0] m_cmd    = 16'h0000;
  logic        m_rdy    = 1'b0;
  int          m_frm = 0, m_ovr = 0, m_sent = 0;
  int          last_end = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic good_stop);
    bus.RX = 1'b0;
    cyc(BD);
    for (int i = 0; i < 8; i++) begin
      bus.RX = b[i];
      cyc(BD);
    end
    bus.RX = good_stop;
    cyc(BD);
    bus.RX = 1'b1;
  endtask

  // One host byte; the model decides pairing, timeout and framing outcome.
  task automatic host_byte(input logic [7:0] b, input logic good_stop);
    int gap;
    gap = cyc_cnt - last_end;
    if (gap >= 200 && gap <= 360) begin
      cyc(200);
      gap = cyc_cnt - last_end;
    end
    if (m_hi_vld && gap > 300) m_hi_vld = 1'b0;
    send_byte(b, good_stop);
    last_end = cyc_cnt;
    if (!good_stop) begin
      m_frm++;
      m_hi_vld = 1'b0;
    end else if (!m_hi_vld) begin
      m_hi     = b;
      m_hi_vld = 1'b1;
    end else begin
      if (m_rdy) m_ovr++;
      m_cmd    = {m_hi, b};
      m_rdy    = 1'b1;
      m_hi_vld = 1'b0;
    end
    cyc(2);
    chk("cmd",     32'(bus.cmd),     32'(m_cmd));
    chk("cmd_rdy", 32'(bus.cmd_rdy), 32'(m_rdy));
    chk("frm_cnt", 32'(cnt_frm),     32'(m_frm));
    chk("ovr_cnt", 32'(cnt_ovr),     32'(m_ovr));
  endtask

  task automatic do_clr();
    bus.clr_cmd_rdy = 1'b1;
    cyc(1);
    bus.clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
    chk("clr_rdy", 32'(bus.cmd_rdy), 32'(0));
  endtask

  // Send a response and decode TX at bit centres; optional mid-frame send_resp.
  task automatic tx_check(input logic [7:0] b, input logic inject);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    bus.resp      = b;
    bus.send_resp = 1'b1;
    cyc(1);
    bus.send_resp = 1'b0;
    bus.resp      = ~b;
    chk("tx_fall", 32'(bus.TX),      32'(0));
    chk("tx_busy", 32'(bus.tx_busy), 32'(1));
    cyc(7);
    for (int k = 0; k < 10; k++) begin
      chk("tx_bit", 32'(bus.TX), 32'(frame[k]));
      if (k == 4 && inject) begin
        bus.resp      = 8'hFF;
        bus.send_resp = 1'b1;
        cyc(1);
        bus.send_resp = 1'b0;
        cyc(15);
      end else if (k < 9) begin
        cyc(16);
      end
    end
    cyc(9);
    m_sent++;
    chk("resp_sent", 32'(bus.resp_sent), 32'(1));
    chk("busy_end",  32'(bus.tx_busy),   32'(0));
    cyc(1);
    chk("resp_sent_1cyc", 32'(bus.resp_sent), 32'(0));
    chk("tx_idle",        32'(bus.TX),        32'(1));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    bus.RX          = 1'b1;
    bus.clr_cmd_rdy = 1'b0;
    bus.resp        = 8'h00;
    bus.send_resp   = 1'b0;
    cyc(4);
    chk("rst_tx",      32'(bus.TX),        32'(1));
    chk("rst_cmd",     32'(bus.cmd),       32'(0));
    chk("rst_rdy",     32'(bus.cmd_rdy),   32'(0));
    chk("rst_busy",    32'(bus.tx_busy),   32'(0));
    chk("rst_pulses",  32'({bus.resp_sent, bus.frm_err, bus.ovr}), 32'(0));
    rst = 1'b0;
    cyc(5);
    last_end = cyc_cnt;

    // basic command and acknowledge
    host_byte(8'h40, 1'b1);
    host_byte(8'h03, 1'b1);
    cyc(20);
    chk("rdy_hold", 32'(bus.cmd_rdy), 32'(1));
    do_clr();

    // response frame with ignored mid-frame request
    tx_check(8'hA5, 1'b1);

    // inter-byte timeout drops a lone high byte
    host_byte(8'h41, 1'b1);
    cyc(400);
    host_byte(8'h05, 1'b1);
    host_byte(8'h41, 1'b1);
    host_byte(8'h07, 1'b1);
    host_byte(8'h09, 1'b1);
    do_clr();

    // framing error on the low byte, then a clean command
    host_byte(8'h42, 1'b1);
    host_byte(8'h01, 1'b0);
    host_byte(8'h42, 1'b1);
    host_byte(8'h01, 1'b1);
    do_clr();

    // overwrite, then overwrite coinciding with acknowledge
    host_byte(8'h00, 1'b1);
    host_byte(8'h01, 1'b1);
    host_byte(8'h00, 1'b1);
    host_byte(8'h02, 1'b1);
    host_byte(8'h00, 1'b1);
    fork
      host_byte(8'h03, 1'b1);
      begin
        cyc(154);
        bus.clr_cmd_rdy = 1'b1;
        cyc(1);
        bus.clr_cmd_rdy = 1'b0;
      end
    join

    // short low glitch is not a start bit
    bus.RX = 1'b0;
    cyc(4);
    bus.RX = 1'b1;
    cyc(200);
    chk("glitch_frm", 32'(cnt_frm),     32'(m_frm));
    chk("glitch_rdy", 32'(bus.cmd_rdy), 32'(m_rdy));
    chk("glitch_cmd", 32'(bus.cmd),     32'(m_cmd));

    // reset in the middle of both an RX and a TX frame
    bus.resp      = 8'h3C;
    bus.send_resp = 1'b1;
    cyc(1);
    bus.send_resp = 1'b0;
    cyc(30);
    bus.RX = 1'b0;
    cyc(40);
    rst    = 1'b1;
    bus.RX = 1'b1;
    cyc(1);
    chk("mid_rst_tx",   32'(bus.TX),      32'(1));
    chk("mid_rst_busy", 32'(bus.tx_busy), 32'(0));
    chk("mid_rst_rdy",  32'(bus.cmd_rdy), 32'(0));
    chk("mid_rst_cmd",  32'(bus.cmd),     32'(0));
    rst      = 1'b0;
    m_hi_vld = 1'b0;
    m_rdy    = 1'b0;
    m_cmd    = 16'h0000;
    cyc(5);
    last_end = cyc_cnt;
    host_byte(8'h12, 1'b1);
    host_byte(8'h34, 1'b1);
    tx_check(8'($urandom), 1'b0);

    // randomized traffic, some of it full duplex
    for (int it = 0; it < 12; it++) begin
      logic [7:0] hb, lb;
      hb = 8'($urandom);
      lb = 8'($urandom);
      cyc($urandom_range(0, 20));
      host_byte(hb, 1'($urandom_range(0, 9) != 0));
      if ($urandom_range(0, 3) == 0) cyc(420);
      else                           cyc($urandom_range(0, 20));
      if (it % 3 == 0) begin
        fork
          host_byte(lb, 1'b1);
          tx_check(8'($urandom), 1'b0);
        join
      end else begin
        host_byte(lb, 1'($urandom_range(0, 9) != 0));
      end
      if ($urandom_range(0, 1) == 1) do_clr();
    end

    cyc(20);
    chk("sent_cnt", 32'(cnt_sent), 32'(m_sent));
    chk("frm_total", 32'(cnt_frm), 32'(m_frm));
    chk("ovr_total", 32'(cnt_ovr), 32'(m_ovr));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_uart_cmd_slave
